// File: rtl/ddr2_traffic_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_tg_pkg
// Purpose  : Shared command encodings, FSM state type and data-LFSR helper
//            for the DDR2 traffic generator.
// Revision : 1.0 - initial release
// ============================================================================
package ddr2_tg_pkg;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } tg_state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_traffic_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_traffic_gen_if
// Purpose  : Host-side bus between the traffic generator (master) and the
//            DDR2 controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ddr2_traffic_gen_if;
  logic [2:0]  cmd;
  logic [1:0]  sz;
  logic [2:0]  op;
  logic [15:0] din;
  logic [24:0] addr;
  logic        fetching;
  logic        ready;
  logic        notfull;
  logic [6:0]  fillcount;
  logic [15:0] dout;
  logic [24:0] raddr;
  logic        validout;

  modport master (
    output cmd, sz, op, din, addr, fetching,
    input  ready, notfull, fillcount, dout, raddr, validout
  );

  modport slave (
    input  cmd, sz, op, din, addr, fetching,
    output ready, notfull, fillcount, dout, raddr, validout
  );
endinterface
`default_nettype wire

// File: rtl/tg_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : tg_lfsr16
// Purpose  : 16-bit Galois LFSR with synchronous load and step enable.
// Revision : 1.0 - initial release
// ============================================================================
module tg_lfsr16
  import ddr2_tg_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  // Load has priority over stepping
  always_comb begin
    value_d = value_q;
    if (load_i)      value_d = seed_i;
    else if (step_i) value_d = lfsr_next(value_q);
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= RESET_VAL;
    else        value_q <= value_d;
  end

  assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/ddr2_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_traffic_gen
// Purpose  : Write pass then read-back pass over one address sequence, with
//            FIFO flow control, outstanding-read limit and data checking.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_traffic_gen
  import ddr2_tg_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 64,
  parameter logic [24:0] BASE_ADDR       = 25'h0,
  parameter int unsigned ADDR_STRIDE     = 1,
  parameter int unsigned FILL_THRESHOLD  = 60,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int unsigned DRAIN_TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               reverse_i,
  ddr2_traffic_gen_if.master ctl,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        err_count_o,
  output logic [24:0]        first_err_addr_o
);

  localparam logic [2:0]  S_IDLE     = IDLE;
  localparam logic [2:0]  S_WAIT_RDY = WAIT_RDY;
  localparam logic [2:0]  S_WRITE    = WRITE;
  localparam logic [2:0]  S_READ     = READ;
  localparam logic [2:0]  S_DRAIN    = DRAIN;
  localparam logic [2:0]  S_DONE     = DONE;
  localparam logic [20:0] C_LAST_IDX = 21'(NUM_WORDS - 1);
  localparam logic [24:0] C_STRIDE   = 25'(ADDR_STRIDE);

  function automatic logic [24:0] next_addr(input logic [24:0] a, input logic rev);
    return rev ? (a - C_STRIDE) : (a + C_STRIDE);
  endfunction

  logic [2:0]  state_q,  state_d;
  logic        rev_q,    rev_d;
  logic [20:0] idx_q,    idx_d;
  logic [24:0] cur_q,    cur_d;
  logic [24:0] exp_q,    exp_d;
  logic [15:0] outst_q,  outst_d;
  logic [31:0] tmo_q,    tmo_d;
  logic [2:0]  cmd_q,    cmd_d;
  logic [15:0] din_q,    din_d;
  logic [24:0] addr_q,   addr_d;
  logic [15:0] err_q,    err_d;
  logic [24:0] ferr_q,   ferr_d;
  logic        pass_q,   pass_d;

  logic [15:0] w_gen_val;
  logic [15:0] w_chk_val;
  logic        w_can_issue;
  logic        w_wr_issue;
  logic        w_rd_issue;
  logic        w_fetching;
  logic        w_ret;
  logic        w_ret_ok;
  logic        w_mismatch;
  logic        w_enter_read;

  assign w_fetching   = (state_q == S_READ) || (state_q == S_DRAIN);
  assign w_can_issue  = ctl.notfull && (32'(ctl.fillcount) < FILL_THRESHOLD);
  assign w_wr_issue   = (state_q == S_WRITE) && w_can_issue;
  assign w_rd_issue   = (state_q == S_READ) && w_can_issue && (32'(outst_q) < MAX_OUTSTANDING);
  assign w_ret        = ctl.validout && w_fetching;
  assign w_ret_ok     = w_ret && (outst_q != 16'd0);
  assign w_mismatch   = w_ret && ((outst_q == 16'd0) || (ctl.dout != w_chk_val) ||
                                  (ctl.raddr != exp_q));
  assign w_enter_read = w_wr_issue && (idx_q == C_LAST_IDX);

  // Generator LFSR: reseeded on every accepted start, advances per write
  tg_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_gen_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start_i && ((state_q == S_IDLE) || (state_q == S_DONE))),
    .step_i  (w_wr_issue),
    .seed_i  (LFSR_SEED),
    .value_o (w_gen_val)
  );

  // Checker LFSR: reseeded on read-pass entry, advances per returned word
  tg_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_chk_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (w_enter_read),
    .step_i  (w_ret),
    .seed_i  (LFSR_SEED),
    .value_o (w_chk_val)
  );

  // Sequencing FSM, command issue, outstanding tracking and result checking
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    exp_d   = exp_q;
    outst_d = outst_q;
    tmo_d   = tmo_q;
    cmd_d   = CMD_NOP;
    din_d   = din_q;
    addr_d  = addr_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WAIT_RDY;
          rev_d   = reverse_i;
          idx_d   = 21'd0;
          cur_d   = BASE_ADDR;
          outst_d = 16'd0;
          tmo_d   = 32'd0;
          err_d   = 16'd0;
          ferr_d  = 25'd0;
          pass_d  = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (ctl.ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (w_wr_issue) begin
          cmd_d  = CMD_SCW;
          din_d  = w_gen_val;
          addr_d = cur_q;
          if (w_enter_read) begin
            state_d = S_READ;
            idx_d   = 21'd0;
            cur_d   = BASE_ADDR;
            exp_d   = BASE_ADDR;
          end else begin
            idx_d = idx_q + 21'd1;
            cur_d = next_addr(cur_q, rev_q);
          end
        end
      end
      S_READ: begin
        if (w_rd_issue) begin
          cmd_d  = CMD_SCR;
          addr_d = cur_q;
          if (idx_q == C_LAST_IDX) begin
            state_d = S_DRAIN;
            tmo_d   = 32'd0;
          end else begin
            idx_d = idx_q + 21'd1;
            cur_d = next_addr(cur_q, rev_q);
          end
        end
      end
      S_DRAIN: begin
        tmo_d = tmo_q + 32'd1;
        if (outst_q == 16'd0) begin
          state_d = S_DONE;
          pass_d  = (err_q == 16'd0);
        end else if (tmo_q == DRAIN_TIMEOUT - 1) begin
          state_d = S_DONE;
          pass_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A simultaneous issue and return cancel out; returns never underflow
    if (w_rd_issue && !w_ret_ok)      outst_d = outst_q + 16'd1;
    else if (!w_rd_issue && w_ret_ok) outst_d = outst_q - 16'd1;

    if (w_ret) exp_d = next_addr(exp_q, rev_q);

    if (w_mismatch) begin
      if (err_q != 16'hFFFF) err_d  = err_q + 16'd1;
      if (err_q == 16'd0)    ferr_d = ctl.raddr;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rev_q   <= 1'b0;
      idx_q   <= 21'd0;
      cur_q   <= 25'd0;
      exp_q   <= 25'd0;
      outst_q <= 16'd0;
      tmo_q   <= 32'd0;
      cmd_q   <= CMD_NOP;
      din_q   <= 16'd0;
      addr_q  <= 25'd0;
      err_q   <= 16'd0;
      ferr_q  <= 25'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rev_q   <= rev_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      exp_q   <= exp_d;
      outst_q <= outst_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

  assign ctl.cmd          = cmd_q;
  assign ctl.sz           = 2'b00;
  assign ctl.op           = 3'b000;
  assign ctl.din          = din_q;
  assign ctl.addr         = addr_q;
  assign ctl.fetching     = w_fetching;
  assign busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_q;

endmodule
`default_nettype wire
